aes_key_expand_ctx: RTL and testbench

Parametrised AES key-expansion sequencer with multiple key contexts. It supports AES-128, AES-192 and AES-256 and expands a cipher key one 32-bit word per cycle into a per-context round-key memory. It shares a single external 32-bit S-box with the cipher datapath. The cipher core reads round keys combinationally by (context, round).

---
 rtl/aes_key_pkg.sv | 55 +++++
 rtl/aes_key_word_gen.sv | 35 +++
 rtl/aes_key_expand_ctx.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_key_expand_ctx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// AES key-schedule shared definitions: key length codes, FSM states, per-mode sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_key_pkg;

    // keylen encodings
    localparam logic [1:0] KL_128  = 2'b00;
    localparam logic [1:0] KL_192  = 2'b01;
    localparam logic [1:0] KL_256  = 2'b10;
    localparam logic [1:0] KL_RSVD = 2'b11;

    // History window depth and per-context memory depth cover the largest mode.
    localparam int MAX_NK    = 8;
    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk(input logic [1:0] kl);
        case (kl)
            KL_128:  nk = 4'd4;
            KL_192:  nk = 4'd6;
            default: nk = 4'd8;
        endcase
    endfunction

    // Number of cipher rounds (last valid round-key index).
    function automatic logic [3:0] nr(input logic [1:0] kl);
        case (kl)
            KL_128:  nr = 4'd10;
            KL_192:  nr = 4'd12;
            default: nr = 4'd14;
        endcase
    endfunction

    // Total expanded words.
    function automatic logic [5:0] nwords(input logic [1:0] kl);
        case (kl)
            KL_128:  nwords = 6'd44;
            KL_192:  nwords = 6'd52;
            default: nwords = 6'd60;
        endcase
    endfunction

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Next key-schedule word: w[i] from w[i-1], w[i-Nk] and the S-box result of w[i-1].
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
// Ports: w_prev = w[i-1], w_nk = w[i-Nk], new_sboxw = SubWord(w[i-1]),
//        j = position within the Nk-word group, rcon/keylen = current round constant and mode,
//        w_new = w[i], rcon_adv = round constant to use from the next word on.
module aes_key_word_gen
    import aes_key_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [31:0] new_sboxw,
    input  logic [2:0]  j,
    input  logic [7:0]  rcon,
    input  logic [1:0]  keylen,
    output logic [31:0] w_new,
    output logic [7:0]  rcon_adv
);

    logic [31:0] temp;

    always_comb begin
        temp     = w_prev;
        rcon_adv = rcon;
        if (j == 3'd0) begin
            // SubWord and RotWord commute (S-box is bytewise), so rotate the S-box output.
            temp     = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0};
            rcon_adv = xtime(rcon);
        end else if ((keylen == KL_256) && (j == 3'd4)) begin
            temp = new_sboxw;
        end
        w_new = w_nk ^ temp;
    end

endmodule

// File: rtl/aes_key_expand_ctx.sv
// Multi-context AES-128/192/256 key expansion, one word per cycle, shared external S-box.
// Latency: ready/ctx_valid rise 42/48/54 edges after the init-sampling edge; reads combinational.
// Backpressure: none; init while busy is ignored, invalid init pulses key_err.
// Ports: key/keylen/ctx_wr/init start an expansion; ctx_rd/round -> round_key read port;
//        ready/busy/ctx_valid/key_err status; sboxw/new_sboxw external S-box handshake.
// Optional: AES_KEY_MEM_ZEROIZE_EN adds input zeroize (clears memory, ctx_valid, window).
module aes_key_expand_ctx
    import aes_key_pkg::*;
#(
    parameter  int NUM_CTX = 2,
    localparam int CW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [255:0]       key,
    input  logic [1:0]         keylen,
    input  logic               init,
    input  logic [CW-1:0]      ctx_wr,
    input  logic [CW-1:0]      ctx_rd,
    input  logic [3:0]         round,
`ifdef AES_KEY_MEM_ZEROIZE_EN
    input  logic               zeroize,
`endif
    output logic [127:0]       round_key,
    output logic               ready,
    output logic               busy,
    output logic [NUM_CTX-1:0] ctx_valid,
    output logic               key_err,
    output logic [31:0]        sboxw,
    input  logic [31:0]        new_sboxw
);

    state_e             state_q, state_d;
    logic [255:0]       key_q;
    logic [1:0]         kl_q;
    logic [CW-1:0]      ctx_q;
    logic [5:0]         i_q;
    logic [2:0]         j_q;
    logic [7:0]         rcon_q;
    logic [31:0]        hist_q [MAX_NK];     // hist_q[0] = w[i-1], hist_q[k] = w[i-1-k]
    logic [31:0]        mem_q  [NUM_CTX][MAX_WORDS];
    logic [1:0]         ctx_mode_q [NUM_CTX]; // mode last expanded into each context

    logic               accept;
    logic               reject;
    logic               init_ok;
    logic               zero_req;
    logic [3:0]         nk_q;
    logic [5:0]         last_i;
    logic [31:0]        key_w     [MAX_NK];
    logic [31:0]        hist_load [MAX_NK];
    logic [31:0]        w_nk;
    logic [31:0]        w_new;
    logic [7:0]         rcon_adv;
    logic               rd_ok;
    logic [5:0]         rd_idx;

`ifdef AES_KEY_MEM_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign init_ok = (keylen != KL_RSVD) && (int'(ctx_wr) < NUM_CTX);
    assign nk_q    = nk(kl_q);
    assign last_i  = nwords(kl_q) - 6'd1;

    // Key words from the latched key, and the window image after LOAD
    // (most recent word first, so w[Nk-1] lands in slot 0).
    always_comb begin
        for (int k = 0; k < MAX_NK; k++) begin
            key_w[3'(k)] = key_q[255-32*k -: 32];
        end
        for (int k = 0; k < MAX_NK; k++) begin
            hist_load[3'(k)] = 32'h0;
            if (k < int'(nk_q)) begin
                hist_load[3'(k)] = key_w[3'(int'(nk_q) - 1 - k)];
            end
        end
    end

    // w[i-Nk] sits Nk-1 slots back in the window.
    always_comb begin
        case (kl_q)
            KL_128:  w_nk = hist_q[3];
            KL_192:  w_nk = hist_q[5];
            default: w_nk = hist_q[7];
        endcase
    end

    aes_key_word_gen u_word_gen (
        .w_prev    (hist_q[0]),
        .w_nk      (w_nk),
        .new_sboxw (new_sboxw),
        .j         (j_q),
        .rcon      (rcon_q),
        .keylen    (kl_q),
        .w_new     (w_new),
        .rcon_adv  (rcon_adv)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control outputs
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        sboxw   = 32'h0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    if (init_ok) begin
                        accept  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_LOAD: state_d = ST_GEN;
            ST_GEN: begin
                sboxw = hist_q[0];
                if (i_q == last_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Zeroize wins over everything, including a same-cycle init.
        if (zero_req) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
            reject  = 1'b0;
        end
    end

    // Datapath: latched request, counters, window, memory, status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '0;
            kl_q       <= '0;
            ctx_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            rcon_q     <= '0;
            hist_q     <= '{default: '0};
            mem_q      <= '{default: '0};
            ctx_mode_q <= '{default: '0};
            ctx_valid  <= '0;
            ready      <= 1'b0;
            key_err    <= 1'b0;
        end else if (zero_req) begin
            key_q     <= '0;
            hist_q    <= '{default: '0};
            mem_q     <= '{default: '0};
            ctx_valid <= '0;
            ready     <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            key_err <= reject;

            if (accept) begin
                key_q              <= key;
                kl_q               <= keylen;
                ctx_q              <= ctx_wr;
                ctx_mode_q[ctx_wr] <= keylen;
                ctx_valid[ctx_wr]  <= 1'b0;
                ready              <= 1'b0;
            end

            if (state_q == ST_LOAD) begin
                for (int k = 0; k < MAX_NK; k++) begin
                    hist_q[3'(k)] <= hist_load[3'(k)];
                    if (k < int'(nk_q)) begin
                        mem_q[ctx_q][6'(k)] <= key_w[3'(k)];
                    end
                end
                i_q    <= {2'b00, nk_q};
                j_q    <= 3'd0;
                rcon_q <= 8'h01;
            end

            if (state_q == ST_GEN) begin
                mem_q[ctx_q][i_q] <= w_new;
                hist_q[0]         <= w_new;
                for (int k = 1; k < MAX_NK; k++) begin
                    hist_q[3'(k)] <= hist_q[3'(k - 1)];
                end
                i_q    <= i_q + 6'd1;
                j_q    <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                rcon_q <= rcon_adv;
            end

            if (state_q == ST_DONE) begin
                ready            <= 1'b1;
                ctx_valid[ctx_q] <= 1'b1;
            end
        end
    end

    // Combinational read port; rounds beyond the context's Nr read as zero.
    always_comb begin
        round_key = 128'h0;
        rd_ok     = 1'b0;
        rd_idx    = 6'd0;
        if (int'(ctx_rd) < NUM_CTX) begin
            if (round <= nr(ctx_mode_q[ctx_rd])) begin
                rd_ok = 1'b1;
            end
        end
        if (rd_ok) begin
            for (int k = 0; k < 4; k++) begin
                rd_idx = {round, 2'b00} + 6'(k);
                round_key[127-32*k -: 32] = mem_q[ctx_rd][rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctx.sv
// Self-checking bench for aes_key_expand_ctx with a behavioural AES S-box and a result scoreboard.
// Latency: checks ready timing of 42/48/54 edges per mode.
// Backpressure: n/a (bench).
module tb_aes_key_expand_ctx;

    localparam int NUM_CTX = 3;
    localparam int CW      = 2;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [255:0]       key = '0;
    logic [1:0]         keylen = 2'b00;
    logic               init = 1'b0;
    logic [CW-1:0]      ctx_wr = '0;
    logic [CW-1:0]      ctx_rd = '0;
    logic [3:0]         round = 4'd0;
`ifdef AES_KEY_MEM_ZEROIZE_EN
    logic               zeroize = 1'b0;
`endif
    logic [127:0]       round_key;
    logic               ready;
    logic               busy;
    logic [NUM_CTX-1:0] ctx_valid;
    logic               key_err;
    logic [31:0]        sboxw;
    logic [31:0]        new_sboxw;

    aes_key_expand_ctx #(.NUM_CTX(NUM_CTX)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .keylen    (keylen),
        .init      (init),
        .ctx_wr    (ctx_wr),
        .ctx_rd    (ctx_rd),
        .round     (round),
`ifdef AES_KEY_MEM_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .round_key (round_key),
        .ready     (ready),
        .busy      (busy),
        .ctx_valid (ctx_valid),
        .key_err   (key_err),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural S-box ----------------
    logic [7:0] sbox_tbl [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h0; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h0;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                        sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};

    // ---------------- checking and scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int t0     = 0;

    typedef struct {
        string         tag;
        logic [CW-1:0] ctx;
        logic [3:0]    rnd;
        logic [127:0]  exp;
    } sb_t;

    sb_t sb_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [CW-1:0] c, input logic [3:0] r,
                        input logic [127:0] e);
        sb_t s;
        s.tag = tag; s.ctx = c; s.rnd = r; s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            @(negedge clk);
            ctx_rd = s.ctx;
            round  = s.rnd;
            #1;
            check(s.tag, round_key, s.exp);
        end
    endtask

    // Drive init for one edge (E0); key/keylen are scrambled right after acceptance.
    task automatic start_exp(input logic [255:0] k, input logic [1:0] kl, input logic [CW-1:0] c);
        @(negedge clk);
        key = k; keylen = kl; ctx_wr = c; init = 1'b1;
        @(posedge clk);
        #1;
        t0     = cyc;
        init   = 1'b0;
        key    = ~k;
        keylen = 2'b11;
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 128'(cyc - t0), 128'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",     128'(ready),     128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_key_err",   128'(key_err),   128'd0);
        check("rst_ctx_valid", 128'(ctx_valid), 128'd0);
        check("rst_round_key", round_key,       128'd0);
        check("rst_sboxw",     128'(sboxw),     128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // AES-128 into context 0, with a stray init while busy
        push("a128_r0",  2'd0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        push("a128_r1",  2'd0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
        push("a128_r10", 2'd0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        push("a128_r11", 2'd0, 4'd11, 128'h0);
        start_exp(K128, 2'b00, 2'd0);
        check("a128_busy_e0",  128'(busy),  128'd1);
        check("a128_ready_e0", 128'(ready), 128'd0);
        @(posedge clk);
        #1;
        check("a128_sboxw_first", 128'(sboxw), 128'h09cf4f3c);
        repeat (4) @(posedge clk);
        @(negedge clk);
        init = 1'b1; keylen = 2'b10; ctx_wr = 2'd2;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("busy_init_no_err", 128'(key_err), 128'd0);
        check("busy_init_busy",   128'(busy),    128'd1);
        wait_ready("a128_latency", 42);
        check("a128_ctx_valid", 128'(ctx_valid), 128'b001);
        drain();

        // AES-192 into context 2
        push("a192_r0",  2'd2, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        push("a192_r1",  2'd2, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push("a192_r12", 2'd2, 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        push("a192_r13", 2'd2, 4'd13, 128'h0);
        start_exp(K192, 2'b01, 2'd2);
        wait_ready("a192_latency", 48);
        check("a192_ctx_valid", 128'(ctx_valid), 128'b101);
        drain();

        // AES-256 into context 1; context 0 stays intact and valid throughout
        push("a256_r0",   2'd1, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781);
        push("a256_r1",   2'd1, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
        push("a256_r2",   2'd1, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
        push("a256_r14",  2'd1, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        push("a256_r15",  2'd1, 4'd15, 128'h0);
        push("ctx0_kept", 2'd0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        start_exp(K256, 2'b10, 2'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        ctx_rd = 2'd0; round = 4'd10;
        #1;
        check("mid_ctx_valid", 128'(ctx_valid), 128'b101);
        check("mid_ctx0_read", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_ready("a256_latency", 54);
        check("a256_ctx_valid", 128'(ctx_valid), 128'b111);
        drain();

        // Rejected inits: reserved keylen, out-of-range context
        @(negedge clk);
        init = 1'b1; keylen = 2'b11; ctx_wr = 2'd0;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("rsvd_key_err",   128'(key_err),   128'd1);
        check("rsvd_busy",      128'(busy),      128'd0);
        check("rsvd_ready",     128'(ready),     128'd1);
        check("rsvd_ctx_valid", 128'(ctx_valid), 128'b111);
        @(posedge clk);
        #1;
        check("rsvd_err_pulse", 128'(key_err), 128'd0);
        @(negedge clk);
        init = 1'b1; keylen = 2'b00; ctx_wr = 2'd3;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("ctx_key_err",   128'(key_err),   128'd1);
        check("ctx_busy",      128'(busy),      128'd0);
        check("ctx_ctx_valid", 128'(ctx_valid), 128'b111);

        // Reset in the middle of GEN, then a fresh AES-128 run
        start_exp(K128, 2'b00, 2'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        ctx_rd = 2'd1; round = 4'd14;
        #1;
        check("mrst_ready",     128'(ready),     128'd0);
        check("mrst_busy",      128'(busy),      128'd0);
        check("mrst_ctx_valid", 128'(ctx_valid), 128'd0);
        check("mrst_round_key", round_key,       128'd0);
        check("mrst_sboxw",     128'(sboxw),     128'd0);
        check("mrst_key_err",   128'(key_err),   128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push("re128_r1",  2'd0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
        push("re128_r10", 2'd0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        start_exp(K128, 2'b00, 2'd0);
        wait_ready("re128_latency", 42);
        check("re128_ctx_valid", 128'(ctx_valid), 128'b001);
        drain();

`ifdef AES_KEY_MEM_ZEROIZE_EN
        // Zeroize during GEN, then zeroize colliding with init
        start_exp(K256, 2'b10, 2'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        check("zero_ctx_valid", 128'(ctx_valid), 128'd0);
        check("zero_busy",      128'(busy),      128'd0);
        check("zero_ready",     128'(ready),     128'd0);
        ctx_rd = 2'd0; round = 4'd10;
        #1;
        check("zero_round_key", round_key, 128'd0);
        @(negedge clk);
        zeroize = 1'b1; init = 1'b1; keylen = 2'b00; ctx_wr = 2'd0; key = K128;
        @(posedge clk);
        #1;
        zeroize = 1'b0; init = 1'b0;
        check("zero_init_busy",    128'(busy),    128'd0);
        check("zero_init_key_err", 128'(key_err), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
